// File: rtl/pong_game_engine.sv
// Pong game-state engine: paddle, ball, score and serve/game-over sequencing.
// All state advances on the single-cycle frame_tick pulse; outputs are registers.
module pong_game_engine #(
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 5
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  // Screen geometry, as 11-bit signed so ball arithmetic never wraps.
  localparam logic signed [10:0] ZERO       = 11'sd0;
  localparam logic signed [10:0] HALF_BALL  = 11'sd4;
  localparam logic signed [10:0] HALF_PAD   = 11'sd30;
  localparam logic signed [10:0] LEFT_FACE  = 11'sd40;
  localparam logic signed [10:0] RIGHT_FACE = 11'sd600;
  localparam logic signed [10:0] SCREEN_W   = 11'sd640;
  localparam logic signed [10:0] TOP_LIM    = 11'sd4;
  localparam logic signed [10:0] BOT_LIM    = 11'sd476;
  localparam logic signed [10:0] BALL_STEP  = 11'(BALL_SPEED);

  localparam logic [9:0]  CENTRE_X  = 10'd320;
  localparam logic [9:0]  CENTRE_Y  = 10'd240;
  localparam logic [9:0]  PAD_MIN   = 10'd30;
  localparam logic [9:0]  PAD_MAX   = 10'd450;
  localparam logic [9:0]  PAD_STEP  = 10'(PADDLE_SPEED);
  localparam logic [15:0] SERVE_LD  = 16'(SERVE_FRAMES);
  localparam logic [3:0]  WIN_VAL   = 4'(WIN_SCORE);

  state_t      st;
  logic        dir_x;      // 1 = moving right
  logic        dir_y;      // 1 = moving down
  logic [15:0] serve_cnt;

  logic signed [10:0] bx, by, p1, p2, nx, ny;
  logic               hit_left, hit_right, miss_left, miss_right;
  logic [3:0]         score1_inc, score2_inc;

  assign state = st;

  // Paddle step with clamping; both or neither button pressed holds position.
  function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                             input logic up,
                                             input logic down);
    logic [9:0] r;
    r = y;
    if (up && !down) begin
      r = (y < PAD_MIN + PAD_STEP) ? PAD_MIN : y - PAD_STEP;
    end else if (down && !up) begin
      r = (y > PAD_MAX - PAD_STEP) ? PAD_MAX : y + PAD_STEP;
    end
    return r;
  endfunction

  // Candidate ball position and collision/miss decisions for this frame.
  always_comb begin
    bx = signed'({1'b0, ball_x});
    by = signed'({1'b0, ball_y});
    p1 = signed'({1'b0, paddle1_y});
    p2 = signed'({1'b0, paddle2_y});
    nx = dir_x ? bx + BALL_STEP : bx - BALL_STEP;
    ny = dir_y ? by + BALL_STEP : by - BALL_STEP;
    // Paddle hits test the crossing of the paddle face and overlap against
    // the current (pre-move) ball and paddle positions.
    hit_left  = !dir_x && (bx - HALF_BALL >= LEFT_FACE) && (nx - HALF_BALL <= LEFT_FACE)
                && (by + HALF_BALL > p1 - HALF_PAD) && (by - HALF_BALL < p1 + HALF_PAD);
    hit_right = dir_x && (bx + HALF_BALL <= RIGHT_FACE) && (nx + HALF_BALL >= RIGHT_FACE)
                && (by + HALF_BALL > p2 - HALF_PAD) && (by - HALF_BALL < p2 + HALF_PAD);
    miss_left  = !hit_left && !hit_right && (nx - HALF_BALL <= ZERO);
    miss_right = !hit_left && !hit_right && !miss_left && (nx + HALF_BALL >= SCREEN_W);
    score1_inc = score1 + 4'd1;
    score2_inc = score2 + 4'd1;
  end

  // Game FSM plus all game-state registers.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      st        <= IDLE;
      paddle1_y <= CENTRE_Y;
      paddle2_y <= CENTRE_Y;
      ball_x    <= CENTRE_X;
      ball_y    <= CENTRE_Y;
      score1    <= 4'd0;
      score2    <= 4'd0;
      game_over <= 1'b0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_cnt <= 16'd0;
    end else begin
      if (frame_tick && st != GAME_OVER) begin
        paddle1_y <= paddle_next(paddle1_y, p1_up, p1_down);
        paddle2_y <= paddle_next(paddle2_y, p2_up, p2_down);
      end

      case (st)
        IDLE: begin
          ball_x <= CENTRE_X;
          ball_y <= CENTRE_Y;
          if (start) begin
            st        <= SERVE;
            serve_cnt <= SERVE_LD;
          end
        end

        SERVE: begin
          ball_x <= CENTRE_X;
          ball_y <= CENTRE_Y;
          if (frame_tick) begin
            if (serve_cnt <= 16'd1) begin
              serve_cnt <= 16'd0;
              st        <= PLAY;
            end else begin
              serve_cnt <= serve_cnt - 16'd1;
            end
          end
        end

        PLAY: begin
          if (frame_tick) begin
            if (miss_left || miss_right) begin
              // Recentre immediately; dir_y carries over into the next serve.
              ball_x <= CENTRE_X;
              ball_y <= CENTRE_Y;
              if (miss_left) begin
                score2 <= score2_inc;
                dir_x  <= 1'b0;
              end else begin
                score1 <= score1_inc;
                dir_x  <= 1'b1;
              end
              if ((miss_left && score2_inc == WIN_VAL) ||
                  (miss_right && score1_inc == WIN_VAL)) begin
                st        <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                st        <= SERVE;
                serve_cnt <= SERVE_LD;
              end
            end else begin
              if (ny <= TOP_LIM) begin
                ball_y <= 10'(TOP_LIM);
                dir_y  <= 1'b1;
              end else if (ny >= BOT_LIM) begin
                ball_y <= 10'(BOT_LIM);
                dir_y  <= 1'b0;
              end else begin
                ball_y <= ny[9:0];
              end
              if (hit_left) begin
                ball_x <= 10'd44;
                dir_x  <= 1'b1;
              end else if (hit_right) begin
                ball_x <= 10'd596;
                dir_x  <= 1'b0;
              end else begin
                ball_x <= nx[9:0];
              end
            end
          end
        end

        GAME_OVER: begin
          if (start) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            dir_x     <= 1'b1;
            game_over <= 1'b0;
            serve_cnt <= SERVE_LD;
            st        <= SERVE;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule
